// File: rtl/fix_point_pkg.sv
// Shared types and helpers for the pipelined signed fixed-point multiplier.
package fix_point_pkg;

   // Rounding applied to the magnitude before the fractional bits are dropped.
   typedef enum logic {
      RND_TRUNC     = 1'b0,
      RND_HALF_AWAY = 1'b1
   } round_mode_e;

   localparam int DEF_WIDTH = 32;
   localparam int DEF_FRAC  = 16;
   localparam int MAX_WIDTH = 32;

   // Magnitude limits are one bit wider than the widest word so that the
   // negative limit 2^(W-1) is representable for every legal width.
   typedef struct packed {
      logic [MAX_WIDTH:0] pos;
      logic [MAX_WIDTH:0] neg;
   } sat_lim_t;

   // Largest magnitude a positive / negative result may carry for a given word width.
   function automatic sat_lim_t sat_limits(input int unsigned width);
      sat_lim_t lim;
      lim.neg = {{MAX_WIDTH{1'b0}}, 1'b1} << (width - 1);
      lim.pos = lim.neg - {{MAX_WIDTH{1'b0}}, 1'b1};
      return lim;
   endfunction

endpackage

// File: rtl/fix_point_mult_pipe_stage.sv
// One valid/ready register slice. The slice loads whenever it is empty or the
// slice after it is moving, so bubbles collapse even while the output stalls.
// The payload is only reset when RESET_DATA is set (used for the output slice).
module fix_point_pipe_stage
   import fix_point_pkg::*;
#(
   parameter int DW         = 8,
   parameter bit RESET_DATA = 1'b0
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          valid_i,
   input  logic [DW-1:0] data_i,
   output logic          ready_o,
   output logic          valid_o,
   output logic [DW-1:0] data_o,
   input  logic          ready_i
);

   logic          valid_q;
   logic          valid_d;
   logic [DW-1:0] data_q;
   logic [DW-1:0] data_d;

   // This slice can advance when it holds nothing or its contents leave this cycle.
   always_comb begin
      ready_o = !valid_q || ready_i;
   end

   // Next contents: take the upstream word when advancing, otherwise hold.
   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (ready_o) begin
         valid_d = valid_i;
         if (valid_i) begin
            data_d = data_i;
         end
      end
   end

   // Occupancy flag, cleared asynchronously so in-flight words are discarded on reset.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         valid_q <= 1'b0;
      end else begin
         valid_q <= valid_d;
      end
   end

   generate
      if (RESET_DATA) begin : g_data_rst
         // Payload register with asynchronous clear, for slices whose data is visible at a port.
         always_ff @(posedge clk_i or negedge rst_n_i) begin
            if (!rst_n_i) begin
               data_q <= '0;
            end else begin
               data_q <= data_d;
            end
         end
      end else begin : g_data_norst
         // Payload register without reset; its contents are meaningless while valid_q is low.
         always_ff @(posedge clk_i) begin
            data_q <= data_d;
         end
      end
   endgenerate

   assign valid_o = valid_q;
   assign data_o  = data_q;

endmodule

// File: rtl/fix_point_mult_pipe.sv
// Pipelined signed fixed-point multiplier: sign/magnitude split, unsigned
// magnitude product, then rounding, range limiting and sign restoration.
// A result is presented on valid_o after the accepting clock edge plus two
// more edges. ready_o is combinational from ready_i through the slice chain.
module fix_point_mult_pipe
   import fix_point_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int FRAC     = DEF_FRAC,
   parameter int ROUND    = 1,
   parameter int SATURATE = 1
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic             valid_i,
   output logic             ready_o,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   output logic             valid_o,
   input  logic             ready_i,
   output logic [WIDTH-1:0] c_o,
   output logic             ovf_o
);

   localparam int          PW    = 2 * WIDTH;
   localparam int          S1W   = 1 + 2 * WIDTH;
   localparam int          S2W   = 1 + PW;
   localparam int          S3W   = WIDTH + 1;
   localparam round_mode_e RMODE = (ROUND != 0) ? RND_HALF_AWAY : RND_TRUNC;
   localparam sat_lim_t    LIM   = sat_limits(WIDTH);
   localparam logic [PW-1:0] POS_LIM = PW'(LIM.pos);
   localparam logic [PW-1:0] NEG_LIM = PW'(LIM.neg);

   // Slice interconnect
   logic           s1_valid;
   logic           s2_valid;
   logic           s1_ready;
   logic           s2_ready;
   logic           s3_ready;
   logic [S1W-1:0] s1_in;
   logic [S1W-1:0] s1_out;
   logic [S2W-1:0] s2_in;
   logic [S2W-1:0] s2_out;
   logic [S3W-1:0] s3_in;
   logic [S3W-1:0] s3_out;

   // Front-end arithmetic
   logic             in_sign;
   logic [WIDTH-1:0] in_mag_a;
   logic [WIDTH-1:0] in_mag_b;

   // Middle arithmetic
   logic             mid_sign;
   logic [WIDTH-1:0] mid_mag_a;
   logic [WIDTH-1:0] mid_mag_b;
   logic [PW-1:0]    mid_prod;

   // Back-end arithmetic
   logic             end_sign;
   logic [PW-1:0]    end_prod;
   logic [PW-1:0]    rnd_add;
   logic [PW-1:0]    rounded;
   logic [PW-1:0]    shifted;
   logic [PW-1:0]    limit;
   logic             over;
   logic [WIDTH-1:0] res_mag;
   logic [WIDTH-1:0] res_val;

   // Split operands into sign and magnitude; -2^(W-1) negates to itself, which
   // read as unsigned is exactly its magnitude 2^(W-1).
   always_comb begin
      in_sign  = a_i[WIDTH-1] ^ b_i[WIDTH-1];
      in_mag_a = a_i[WIDTH-1] ? -a_i : a_i;
      in_mag_b = b_i[WIDTH-1] ? -b_i : b_i;
      s1_in    = {in_sign, in_mag_a, in_mag_b};
   end

   fix_point_pipe_stage #(
      .DW         (S1W),
      .RESET_DATA (1'b0)
   ) u_s1 (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .valid_i (valid_i),
      .data_i  (s1_in),
      .ready_o (s1_ready),
      .valid_o (s1_valid),
      .data_o  (s1_out),
      .ready_i (s2_ready)
   );

   // Full-width unsigned product of the two magnitudes.
   always_comb begin
      {mid_sign, mid_mag_a, mid_mag_b} = s1_out;
      mid_prod = PW'(mid_mag_a) * PW'(mid_mag_b);
      s2_in    = {mid_sign, mid_prod};
   end

   fix_point_pipe_stage #(
      .DW         (S2W),
      .RESET_DATA (1'b0)
   ) u_s2 (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .valid_i (s1_valid),
      .data_i  (s2_in),
      .ready_o (s2_ready),
      .valid_o (s2_valid),
      .data_o  (s2_out),
      .ready_i (s3_ready)
   );

   // Round the magnitude, drop fractional bits, limit or wrap, then restore the sign.
   // The product never exceeds 2^(2W-2), so adding the rounding constant cannot carry out.
   // Negating a zero magnitude gives zero, so there is no negative zero.
   always_comb begin
      {end_sign, end_prod} = s2_out;
      rnd_add = (RMODE == RND_HALF_AWAY) ? (PW'(1) << (FRAC - 1)) : '0;
      rounded = end_prod + rnd_add;
      shifted = rounded >> FRAC;
      limit   = end_sign ? NEG_LIM : POS_LIM;
      over    = shifted > limit;
      if (over && (SATURATE != 0)) begin
         res_mag = limit[WIDTH-1:0];
      end else begin
         res_mag = shifted[WIDTH-1:0];
      end
      res_val = end_sign ? -res_mag : res_mag;
      s3_in   = {over, res_val};
   end

   fix_point_pipe_stage #(
      .DW         (S3W),
      .RESET_DATA (1'b1)
   ) u_s3 (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .valid_i (s2_valid),
      .data_i  (s3_in),
      .ready_o (s3_ready),
      .valid_o (valid_o),
      .data_o  (s3_out),
      .ready_i (ready_i)
   );

   assign ready_o = s1_ready;
   assign ovf_o   = s3_out[S3W-1];
   assign c_o     = s3_out[WIDTH-1:0];

endmodule

// File: doc/fix_point_mult_pipe.md
Name: fix_point_mult_pipe

Overview:
- Parametrised, pipelined signed fixed-point multiplier. Successor to the team's combinational Q15.16 multiplier.
- Generic width and fraction split, selectable rounding and saturation, overflow flag.
- Valid/ready handshake with backpressure on both sides.
- Sits in the IIR datapath between coefficient/sample registers and the accumulator.

Parameters:
- WIDTH, 32, total word width incl. sign; legal 8..32.
- FRAC, 16, fractional bits; legal 1..WIDTH-1.
- ROUND, 1, 0 = truncate magnitude; 1 = round half away from zero.
- SATURATE, 1, 1 = clamp on overflow; 0 = wrap (keep low WIDTH bits of magnitude, then apply sign).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- valid_i  in  1  input operands valid.
- ready_o  out  1  block can accept operands this cycle.
- a_i  in  WIDTH  operand A, two's complement, FRAC fractional bits.
- b_i  in  WIDTH  operand B, same format.
- valid_o  out  1  result valid.
- ready_i  in  1  downstream accepts result.
- c_o  out  WIDTH  product, same format as inputs.
- ovf_o  out  1  result overflowed; qualified by valid_o.

Behaviour:
- One clock; reset is asynchronous and active-low; clk_i/rst_n_i.
- Reset: all stage valid bits, valid_o, ovf_o and c_o cleared to 0. ready_o = 1 once out of reset.
- Transfer on a port occurs when valid and ready are both high at a rising edge.
- Three register stages; latency = 3 cycles from input transfer to valid_o when unstalled. Throughput 1/cycle.
- S1: capture sign = a[W-1]^b[W-1] and W-bit magnitudes |a|, |b|. The most negative input -2^(W-1) has magnitude 2^(W-1) and must not overflow.
- S2: unsigned 2W-bit product of magnitudes.
- S3:
  - Add 2^(FRAC-1) if ROUND=1.
  - Shift right FRAC.
  - Limit check: positive limit 2^(W-1)-1; negative limit 2^(W-1).
  - Over limit with SATURATE=1: c_o = 0x7F..F (pos) or 0x80..0 (neg), ovf_o = 1.
  - Over limit with SATURATE=0: wrap as defined above, ovf_o = 1.
  - Apply sign by negation.
  - A zero magnitude yields 0 regardless of sign, never a negative zero.
- Flow control, per stage k: advance_k = !valid_k | advance_{k+1}, with advance_out = !valid_o | ready_i.
  - Bubbles collapse: an empty stage accepts new data even while later stages stall.
  - ready_o = advance_1, derived combinationally from ready_i through the chain; no registered skid.
- Stall: when valid_o && !ready_i, c_o, ovf_o and valid_o hold stable. Up to 3 results are buffered, then ready_o = 0.
- Simultaneous input transfer and output transfer in the same cycle are both honoured; no loss or duplication.
- valid_i with ready_o = 0: operands are not captured; the source must hold them.
- Reset mid-operation: in-flight results are discarded, and no valid_o occurs after reset release until new inputs arrive.
- Data registers need no reset except c_o/ovf_o; valid bits must be reset.

Decomposition:
- Package fix_point_pkg:
  - round_mode_e enum (RND_TRUNC, RND_HALF_AWAY).
  - Default WIDTH/FRAC localparams.
  - Function sat_limits(width) returning the pos/neg magnitude limits.
- Sub-module fix_point_pipe_stage: one parametrised valid/ready register slice (data width param, ready/valid, async reset of valid). Instantiated three times, with arithmetic between instances.

Test Plan (WIDTH=32, FRAC=16 unless noted):
- Basic products, ready_i = 1, ROUND=1:
  - a=0x00018000 (1.5), b=0x00020000 (2.0) -> c_o=0x00030000, ovf_o=0, valid_o exactly 3 cycles after transfer.
  - a=0xFFFE8000 (-1.5), b=0x00020000 -> c_o=0xFFFD0000.
- Saturation, SATURATE=1:
  - a=0x40000000, b=0x00040000 -> c_o=0x7FFFFFFF, ovf_o=1.
  - a=0xC0000000, b=0x00040000 -> c_o=0x80000000, ovf_o=1.
  - a=0x80000000, b=0xFFFF0000 (-1.0) -> c_o=0x7FFFFFFF, ovf_o=1.
- Rounding, b=0x00008000 (0.5):
  - a=0x00000001, ROUND=1 -> c_o=0x00000001.
  - Same operands, ROUND=0 -> c_o=0x00000000.
  - a=0xFFFFFFFF, ROUND=1 -> c_o=0xFFFFFFFF.
- Backpressure: stream 6 operand pairs with ready_i=0 for cycles 4..9.
  - ready_o drops after 3 buffered results; c_o stays stable while stalled.
  - All 6 results emerge in order, no drops or duplicates, with a concurrent in/out transfer checked.
- Bubble collapse: valid_i pulses every other cycle while ready_i toggles -> output sequence matches a reference model; ready_o is never low while any stage is empty.
- Reset mid-stream: assert rst_n_i asynchronously with 3 results in flight -> valid_o=0, c_o=0, ovf_o=0 immediately. After release, no valid_o until new input; the first new result is correct after 3 cycles.
